si_uart_master: RTL and testbench
=================================

Name: si_uart_master

Overview:
Initiator for the simple register interface (addr/re/we/wd/rd), driven by a byte stream from a UART receiver. It decodes command bytes into single simple-interface read or write transactions. It returns the read data, or an acknowledge byte, to a UART transmitter. This gives the host a register-access port into any simple-interface peripheral, for example the UART, GPIO or timer blocks.

Parameters:
DW, 32, simple-interface data width; must be a multiple of 8; NB = DW/8 bytes per data word
TIMEOUT, 50000, idle clock cycles allowed between command bytes before an incomplete command is aborted
ACK_BYTE, 8'h4B, response byte sent after a completed write

Ports:
clk  input  1  clock
rstn  input  1  reset; synchronous, active-high (asserted = 1)
rx_data  input  8  received byte
rx_valid  input  1  one-cycle strobe; rx_data is valid; no backpressure
tx_data  output  8  response byte
tx_valid  output  1  response byte available
tx_ready  input  1  transmitter accepts tx_data when tx_valid && tx_ready
addr  output  4  simple-interface address
re  output  1  simple-interface read enable, one-cycle pulse
we  output  1  simple-interface write enable, one-cycle pulse
wd  output  DW  simple-interface write data
rd  input  DW  simple-interface read data; combinational from addr
busy  output  1  high in any state other than IDLE
err  output  1  one-cycle pulse on dropped byte or timeout

Behaviour:
- Reset values: state IDLE; addr=0, wd=0, re=0, we=0, tx_data=0, tx_valid=0, busy=0, err=0; all byte and timeout counters cleared. Reset aborts any operation in progress without issuing re or we.
- Command byte format: bit7 = 1 for write, 0 for read; bits 6:4 must be 0; bits 3:0 = address.
- IDLE, on rx_valid:
  - Reserved bits nonzero: byte dropped, err pulse, stay in IDLE.
  - Otherwise addr <= cmd[3:0].
  - Write command: go to GET_DATA with byte_cnt=0.
  - Read command: go to ISSUE.
- GET_DATA, on each rx_valid:
  - wd[8*byte_cnt +: 8] <= rx_data (data arrives LSB first).
  - After the NB-th byte, go to ISSUE.
- GET_DATA timeout:
  - The timeout counter clears on every rx_valid and otherwise increments.
  - When it reaches TIMEOUT-1: err pulse, go to IDLE, no we issued.
- ISSUE lasts exactly one cycle:
  - Write: we=1.
  - Read: re=1, and rd is captured into the response buffer in that same cycle.
  - addr is stable from ISSUE-1 through ISSUE.
  - Next state is SEND.
- SEND:
  - tx_valid=1; tx_data = ACK_BYTE for a write, or response byte k (LSB first) for a read.
  - tx_data is held stable until tx_valid && tx_ready; the byte index advances on each handshake.
  - After the last byte (1 for a write, NB for a read), tx_valid drops in the same edge and the state goes to IDLE.
- rx_valid in ISSUE or SEND: byte dropped, err pulse; the transaction and response are unaffected.
- Latency:
  - Read command strobe at cycle T: re at T+1, tx_valid at T+2.
  - Last write data byte at T: we at T+1, ACK tx_valid at T+2.
- addr and wd hold their last values after a transaction. re and we are never high together and never high outside ISSUE.

Optional Feature:
SI_MASTER_CSUM_EN:
- Defined:
  - Every command carries one trailing checksum byte: XOR of the command byte and all data bytes.
  - The block waits for it in state GET_CSUM; the timeout also applies there.
  - Mismatch: no re/we, err pulse, and a single NAK byte 8'h4E is sent.
  - Every response is followed by an XOR checksum byte of the response bytes.
- Undefined: no GET_CSUM state and no checksum bytes; framing is exactly as in Behaviour.

Decomposition:
- Package si_master_pkg holds:
  - the state enum (IDLE, GET_DATA, GET_CSUM, ISSUE, SEND);
  - CMD_WR_BIT=7, CMD_RSV_MSK=8'h70, NAK_BYTE=8'h4E.
- One sub-module, si_master_tmo: loadable timeout counter with clear, enable and expire outputs, parameterised by TIMEOUT.

Test Plan:
- Write: bytes 88,34,12,00,00 -> one-cycle we with addr=8, wd=32'h00001234; then tx byte 4B; busy falls after the handshake.
- Read: byte 04 with rd=32'hA5A50007 -> one-cycle re with addr=4 one cycle after the strobe; tx bytes 07,00,A5,A5 in order.
- Backpressure: during a read response, tx_ready=0 for 10 cycles -> tx_valid=1 and tx_data stable the whole time; all 4 bytes delivered exactly once.
- Timeout: bytes 88,01, then silence for TIMEOUT cycles -> err pulse, IDLE, no we; a following read 00 completes normally.
- Drops: byte 48 in IDLE, and any byte during SEND -> err pulse each time; no transaction issued; response bytes unchanged.
- Reset after 2 of 4 data bytes -> IDLE, no we, outputs at reset values; a following full write 80,01,00,00,00 gives we with wd=1.

Source files
------------

// File: rtl/si_master_pkg.sv
// Shared types and constants for the simple-interface UART master.
// The GET_CSUM state is only reached when SI_MASTER_CSUM_EN is defined.
package si_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_DATA,
        GET_CSUM,
        ISSUE,
        SEND
    } state_t;

    localparam int         CMD_WR_BIT  = 7;
    localparam logic [7:0] CMD_RSV_MSK = 8'h70;
    localparam logic [7:0] NAK_BYTE    = 8'h4E;

endpackage

// File: rtl/si_master_tmo.sv
// Inter-byte timeout counter: restarts on clr or while disabled, and flags
// expiry on the cycle the count reaches TIMEOUT-1 with no clear pending.
module si_master_tmo
    import si_master_pkg::*;
#(
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    assign expire = en && !clr && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr || !en || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/si_uart_master.sv
// UART byte-stream to simple-interface bridge: decodes read/write commands,
// issues one re/we pulse, returns read data or an ACK. Option: SI_MASTER_CSUM_EN.
module si_uart_master
    import si_master_pkg::*;
#(
    parameter int         DW       = 32,
    parameter int         TIMEOUT  = 50000,
    parameter logic [7:0] ACK_BYTE = 8'h4B
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [3:0]    addr,
    output logic          re,
    output logic          we,
    output logic [DW-1:0] wd,
    input  logic [DW-1:0] rd,
    output logic          busy,
    output logic          err
);

    localparam int NB = DW / 8;

    state_t        state;
    logic [7:0]    byte_cnt;
    logic [7:0]    last_idx;
    logic          is_wr;
    logic [DW-1:0] rbuf;
    logic          collecting;
    logic          tmo_expire;
`ifdef SI_MASTER_CSUM_EN
    logic [7:0]    rx_csum;
    logic [7:0]    tx_csum;
    logic          is_nak;
`endif

    assign collecting = (state == GET_DATA) || (state == GET_CSUM);

    si_master_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk    (clk),
        .rst    (rstn),
        .clr    (rx_valid),
        .en     (collecting),
        .expire (tmo_expire)
    );

    // Index of the final response byte; the checksum adds one trailing byte.
    always_comb begin
`ifdef SI_MASTER_CSUM_EN
        if (is_nak) begin
            last_idx = 8'd0;
        end else begin
            last_idx = is_wr ? 8'd1 : 8'(NB);
        end
`else
        last_idx = is_wr ? 8'd0 : 8'(NB - 1);
`endif
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state    <= IDLE;
            addr     <= '0;
            wd       <= '0;
            re       <= 1'b0;
            we       <= 1'b0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            byte_cnt <= '0;
            is_wr    <= 1'b0;
            rbuf     <= '0;
`ifdef SI_MASTER_CSUM_EN
            rx_csum  <= '0;
            tx_csum  <= '0;
            is_nak   <= 1'b0;
`endif
        end else begin
            re  <= 1'b0;
            we  <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if ((rx_data & CMD_RSV_MSK) != 8'h00) begin
                            err <= 1'b1;
                        end else begin
                            addr     <= rx_data[3:0];
                            is_wr    <= rx_data[CMD_WR_BIT];
                            byte_cnt <= '0;
                            busy     <= 1'b1;
`ifdef SI_MASTER_CSUM_EN
                            rx_csum  <= rx_data;
                            is_nak   <= 1'b0;
                            state    <= rx_data[CMD_WR_BIT] ? GET_DATA : GET_CSUM;
`else
                            if (rx_data[CMD_WR_BIT]) begin
                                state <= GET_DATA;
                            end else begin
                                state <= ISSUE;
                                re    <= 1'b1;
                            end
`endif
                        end
                    end
                end
                GET_DATA: begin
                    if (rx_valid) begin
                        // Data arrives LSB first; constant indices keep the select static.
                        for (int i = 0; i < NB; i++) begin
                            if (byte_cnt == 8'(i)) wd[8*i +: 8] <= rx_data;
                        end
                        byte_cnt <= byte_cnt + 8'd1;
`ifdef SI_MASTER_CSUM_EN
                        rx_csum  <= rx_csum ^ rx_data;
                        if (byte_cnt == 8'(NB - 1)) state <= GET_CSUM;
`else
                        if (byte_cnt == 8'(NB - 1)) begin
                            state <= ISSUE;
                            we    <= 1'b1;
                        end
`endif
                    end else if (tmo_expire) begin
                        err   <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
`ifdef SI_MASTER_CSUM_EN
                GET_CSUM: begin
                    if (rx_valid) begin
                        if (rx_data == rx_csum) begin
                            state <= ISSUE;
                            we    <= is_wr;
                            re    <= !is_wr;
                        end else begin
                            err      <= 1'b1;
                            is_nak   <= 1'b1;
                            state    <= SEND;
                            tx_valid <= 1'b1;
                            tx_data  <= NAK_BYTE;
                            byte_cnt <= '0;
                            tx_csum  <= '0;
                        end
                    end else if (tmo_expire) begin
                        err   <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
`endif
                ISSUE: begin
                    err      <= rx_valid;
                    state    <= SEND;
                    tx_valid <= 1'b1;
                    byte_cnt <= '0;
`ifdef SI_MASTER_CSUM_EN
                    tx_csum  <= '0;
`endif
                    if (is_wr) begin
                        tx_data <= ACK_BYTE;
                    end else begin
                        tx_data <= rd[7:0];
                        rbuf    <= rd >> 8;
                    end
                end
                SEND: begin
                    err <= rx_valid;
                    if (tx_valid && tx_ready) begin
                        byte_cnt <= byte_cnt + 8'd1;
`ifdef SI_MASTER_CSUM_EN
                        tx_csum  <= tx_csum ^ tx_data;
`endif
                        if (byte_cnt == last_idx) begin
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                            busy     <= 1'b0;
`ifdef SI_MASTER_CSUM_EN
                        end else if (byte_cnt == last_idx - 8'd1) begin
                            tx_data <= tx_csum ^ tx_data;
`endif
                        end else begin
                            tx_data <= rbuf[7:0];
                            rbuf    <= rbuf >> 8;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_si_uart_master.sv
// Self-checking bench for si_uart_master (default framing, no checksum).
// A register-file peripheral answers rd; a byte-level model predicts traffic.
module tb_si_uart_master;

    localparam int DW  = 32;
    localparam int NB  = DW / 8;
    localparam int TMO = 40;
    localparam logic [7:0] ACK = 8'h4B;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic [3:0]    addr;
    logic          re;
    logic          we;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    logic          busy;
    logic          err;

    logic [DW-1:0] regs [16];
    logic [DW-1:0] regs_m [16];
    assign rd = regs[addr];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_strobe = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    bit rand_ready = 1'b0;
    logic txv_prev = 1'b0;

    logic [3:0]    wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    int            wr_cyc_q  [$];
    logic [3:0]    rd_addr_q [$];
    int            rd_cyc_q  [$];
    int            txv_cyc_q [$];
    logic [7:0]    tx_q      [$];

    si_uart_master #(.DW(DW), .TIMEOUT(TMO), .ACK_BYTE(ACK)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .addr     (addr),
        .re       (re),
        .we       (we),
        .wd       (wd),
        .rd       (rd),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Records the current cycle's bus activity, then advances one clock.
    task automatic tick();
        if (we) begin
            wr_addr_q.push_back(addr);
            wr_data_q.push_back(wd);
            wr_cyc_q.push_back(cyc);
            regs[addr] = wd;
        end
        if (re) begin
            rd_addr_q.push_back(addr);
            rd_cyc_q.push_back(cyc);
        end
        if (re && we) both_cnt++;
        if (err) err_cnt++;
        if (tx_valid && !txv_prev) txv_cyc_q.push_back(cyc);
        txv_prev = tx_valid;
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        @(posedge clk);
        #1;
        cyc++;
        if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        rd_addr_q.delete(); rd_cyc_q.delete();
        txv_cyc_q.delete(); tx_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        last_strobe = cyc;
        tick();
        rx_valid = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (!busy && !tx_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_txv(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (tx_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [DW-1:0] w, input int k);
        logic [DW-1:0] s;
        s = w >> (8 * k);
        return s[7:0];
    endfunction

    task automatic test_reset();
        rstn = 1'b1;
        repeat (3) tick();
        n_checks++; if (addr !== 4'h0)      begin n_fail++; $display("FAIL reset_addr: got %h expected 0", addr); end
        n_checks++; if (wd !== '0)          begin n_fail++; $display("FAIL reset_wd: got %h expected 0", wd); end
        n_checks++; if (re !== 1'b0 || we !== 1'b0) begin n_fail++; $display("FAIL reset_re_we: got re=%b we=%b expected 0/0", re, we); end
        n_checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx: got v=%b d=%h expected 0/00", tx_valid, tx_data); end
        n_checks++; if (busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_busy_err: got busy=%b err=%b expected 0/0", busy, err); end
        rstn = 1'b0;
        tick();
        err_cnt = 0;
        clear_logs();
    endtask

    task automatic test_write();
        bit ok;
        int e0;
        logic [7:0] cmd [5];
        cmd = '{8'h88, 8'h34, 8'h12, 8'h00, 8'h00};
        e0 = err_cnt;
        clear_logs();
        for (int i = 0; i < 5; i++) begin
            send_byte(cmd[i]);
            if (i == 0) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy: got %b expected 1", busy); end
            end
        end
        wait_done(50, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL write_done: busy/tx_valid still high after 50 cycles"); end
        n_checks++; if (wr_addr_q.size() !== 1 || rd_addr_q.size() !== 0) begin n_fail++; $display("FAIL write_pulses: got we=%0d re=%0d expected 1/0", wr_addr_q.size(), rd_addr_q.size()); end
        if (wr_addr_q.size() >= 1) begin
            n_checks++; if (wr_addr_q[0] !== 4'h8) begin n_fail++; $display("FAIL write_addr: got %h expected 8", wr_addr_q[0]); end
            n_checks++; if (wr_data_q[0] !== 32'h0000_1234) begin n_fail++; $display("FAIL write_wd: got %h expected 00001234", wr_data_q[0]); end
            n_checks++; if (wr_cyc_q[0] !== last_strobe + 1) begin n_fail++; $display("FAIL write_we_latency: got %0d expected %0d", wr_cyc_q[0], last_strobe + 1); end
        end
        n_checks++; if (txv_cyc_q.size() < 1 || txv_cyc_q[0] !== last_strobe + 2) begin n_fail++; $display("FAIL write_ack_latency: got %0d entries expected tx_valid at %0d", txv_cyc_q.size(), last_strobe + 2); end
        n_checks++; if (tx_q.size() !== 1 || tx_q[0] !== ACK) begin n_fail++; $display("FAIL write_ack: got %0d bytes first=%h expected 1 byte 4b", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'h00); end
        n_checks++; if (err_cnt !== e0) begin n_fail++; $display("FAIL write_err: got %0d err pulses expected 0", err_cnt - e0); end
    endtask

    task automatic test_read();
        bit ok;
        bit bad;
        logic [DW-1:0] v;
        v = 32'hA5A5_0007;
        regs[4] = v;
        clear_logs();
        send_byte(8'h04);
        wait_done(50, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL read_done: response did not finish in 50 cycles"); end
        n_checks++; if (rd_addr_q.size() !== 1 || wr_addr_q.size() !== 0) begin n_fail++; $display("FAIL read_pulses: got re=%0d we=%0d expected 1/0", rd_addr_q.size(), wr_addr_q.size()); end
        if (rd_addr_q.size() >= 1) begin
            n_checks++; if (rd_addr_q[0] !== 4'h4) begin n_fail++; $display("FAIL read_addr: got %h expected 4", rd_addr_q[0]); end
            n_checks++; if (rd_cyc_q[0] !== last_strobe + 1) begin n_fail++; $display("FAIL read_re_latency: got %0d expected %0d", rd_cyc_q[0], last_strobe + 1); end
        end
        n_checks++; if (txv_cyc_q.size() < 1 || txv_cyc_q[0] !== last_strobe + 2) begin n_fail++; $display("FAIL read_tx_latency: tx_valid did not rise at %0d", last_strobe + 2); end
        bad = (tx_q.size() != NB);
        for (int k = 0; k < NB && !bad; k++) bad = (tx_q[k] !== byte_of(v, k));
        n_checks++; if (bad) begin n_fail++; $display("FAIL read_bytes: got %0d bytes first=%h expected 07 00 a5 a5", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'h00); end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit bad;
        logic [7:0] held;
        logic [DW-1:0] v;
        v = {$urandom()};
        regs[5] = v;
        clear_logs();
        tx_ready = 1'b0;
        send_byte(8'h05);
        wait_txv(20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_txv: tx_valid never rose"); end
        held = tx_data;
        n_checks++; if (held !== byte_of(v, 0)) begin n_fail++; $display("FAIL bp_first: got %h expected %h", held, byte_of(v, 0)); end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++; if (tx_valid !== 1'b1 || tx_data !== held) begin n_fail++; $display("FAIL bp_hold: cycle %0d got v=%b d=%h expected 1/%h", i, tx_valid, tx_data, held); end
        end
        tx_ready = 1'b1;
        wait_done(50, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_done: response did not finish"); end
        bad = (tx_q.size() != NB);
        for (int k = 0; k < NB && !bad; k++) bad = (tx_q[k] !== byte_of(v, k));
        n_checks++; if (bad) begin n_fail++; $display("FAIL bp_bytes: got %0d bytes expected %0d of %h", tx_q.size(), NB, v); end
    endtask

    task automatic test_timeout();
        bit ok;
        bit bad;
        int e0;
        int waited;
        e0 = err_cnt;
        clear_logs();
        send_byte(8'h88);
        send_byte(8'h01);
        waited = -1;
        for (int i = 0; i < TMO + 10; i++) begin
            tick();
            if (err_cnt != e0) begin
                waited = i;
                break;
            end
        end
        n_checks++; if (waited < TMO - 2 || waited > TMO + 2) begin n_fail++; $display("FAIL tmo_err: err after %0d idle cycles expected about %0d", waited, TMO); end
        tick();
        n_checks++; if (busy !== 1'b0 || wr_addr_q.size() !== 0) begin n_fail++; $display("FAIL tmo_abort: got busy=%b we=%0d expected 0/0", busy, wr_addr_q.size()); end
        clear_logs();
        send_byte(8'h00);
        wait_done(50, ok);
        bad = !ok || (tx_q.size() != NB);
        for (int k = 0; k < NB && !bad; k++) bad = (tx_q[k] !== byte_of(regs[0], k));
        n_checks++; if (bad) begin n_fail++; $display("FAIL tmo_recover: got %0d bytes ok=%b expected %0d bytes of %h", tx_q.size(), ok, NB, regs[0]); end
    endtask

    task automatic test_drops();
        bit ok;
        bit bad;
        int e0;
        logic [DW-1:0] v;
        v = 32'h1357_9BDF;
        regs[3] = v;
        e0 = err_cnt;
        clear_logs();
        send_byte(8'h48);
        tick();
        tick();
        n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL drop_idle_err: got %0d pulses expected 1", err_cnt - e0); end
        n_checks++; if (busy !== 1'b0 || wr_addr_q.size() !== 0 || rd_addr_q.size() !== 0) begin n_fail++; $display("FAIL drop_idle_txn: got busy=%b we=%0d re=%0d expected 0/0/0", busy, wr_addr_q.size(), rd_addr_q.size()); end
        tx_ready = 1'b0;
        send_byte(8'h03);
        wait_txv(20, ok);
        send_byte(8'h99);
        tick();
        n_checks++; if (err_cnt - e0 !== 2) begin n_fail++; $display("FAIL drop_send_err: got %0d pulses expected 2", err_cnt - e0); end
        tx_ready = 1'b1;
        wait_done(50, ok);
        bad = !ok || (tx_q.size() != NB);
        for (int k = 0; k < NB && !bad; k++) bad = (tx_q[k] !== byte_of(v, k));
        n_checks++; if (bad) begin n_fail++; $display("FAIL drop_send_bytes: got %0d bytes ok=%b expected %0d bytes of %h", tx_q.size(), ok, NB, v); end
        n_checks++; if (rd_addr_q.size() !== 1 || wr_addr_q.size() !== 0) begin n_fail++; $display("FAIL drop_send_txn: got re=%0d we=%0d expected 1/0", rd_addr_q.size(), wr_addr_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_logs();
        send_byte(8'h88);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
        n_checks++; if (busy !== 1'b0 || addr !== 4'h0 || wd !== '0 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs: got busy=%b addr=%h wd=%h txv=%b expected 0/0/0/0", busy, addr, wd, tx_valid); end
        tick();
        n_checks++; if (wr_addr_q.size() !== 0) begin n_fail++; $display("FAIL rstmid_no_we: got %0d we pulses expected 0", wr_addr_q.size()); end
        clear_logs();
        send_byte(8'h80);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_done(50, ok);
        n_checks++; if (wr_data_q.size() !== 1 || wr_data_q[0] !== 32'h1 || wr_addr_q[0] !== 4'h0) begin n_fail++; $display("FAIL rstmid_write: got %0d writes wd=%h expected 1 write wd=00000001", wr_data_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : '0); end
        n_checks++; if (tx_q.size() !== 1 || tx_q[0] !== ACK) begin n_fail++; $display("FAIL rstmid_ack: got %0d bytes expected 1 ack", tx_q.size()); end
    endtask

    // Random commands with random gaps and tx backpressure against a register-file model.
    task automatic test_random();
        bit ok;
        bit bad;
        bit is_wr;
        int e0;
        logic [3:0] a;
        logic [DW-1:0] d;
        logic [7:0] exp_q [$];
        for (int i = 0; i < 16; i++) regs_m[i] = regs[i];
        rand_ready = 1'b1;
        for (int t = 0; t < 24; t++) begin
            is_wr = 1'($urandom_range(0, 1));
            a = 4'($urandom_range(0, 15));
            d = {$urandom()};
            e0 = err_cnt;
            exp_q.delete();
            clear_logs();
            send_byte({is_wr, 3'b000, a});
            if (is_wr) begin
                for (int k = 0; k < NB; k++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send_byte(byte_of(d, k));
                end
                regs_m[a] = d;
                exp_q.push_back(ACK);
            end else begin
                for (int k = 0; k < NB; k++) exp_q.push_back(byte_of(regs_m[a], k));
            end
            wait_done(200, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_done[%0d]: response did not finish", t); end
            n_checks++;
            if (is_wr) begin
                if (wr_addr_q.size() !== 1 || rd_addr_q.size() !== 0 || wr_addr_q[0] !== a || wr_data_q[0] !== d) begin
                    n_fail++;
                    $display("FAIL rand_write[%0d]: got %0d writes addr=%h wd=%h expected addr=%h wd=%h", t, wr_addr_q.size(), (wr_addr_q.size() > 0) ? wr_addr_q[0] : 4'h0, (wr_data_q.size() > 0) ? wr_data_q[0] : '0, a, d);
                end
            end else begin
                if (rd_addr_q.size() !== 1 || wr_addr_q.size() !== 0 || rd_addr_q[0] !== a) begin
                    n_fail++;
                    $display("FAIL rand_read[%0d]: got %0d reads addr=%h expected 1 read addr=%h", t, rd_addr_q.size(), (rd_addr_q.size() > 0) ? rd_addr_q[0] : 4'h0, a);
                end
            end
            bad = (tx_q.size() != exp_q.size());
            for (int k = 0; k < exp_q.size() && !bad; k++) bad = (tx_q[k] !== exp_q[k]);
            n_checks++; if (bad) begin n_fail++; $display("FAIL rand_tx[%0d]: got %0d bytes first=%h expected %0d bytes first=%h", t, tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'h00, exp_q.size(), exp_q[0]); end
            n_checks++; if (err_cnt !== e0) begin n_fail++; $display("FAIL rand_err[%0d]: got %0d err pulses expected 0", t, err_cnt - e0); end
            repeat ($urandom_range(0, 3)) tick();
        end
        rand_ready = 1'b0;
        tx_ready = 1'b1;
        n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL re_we_overlap: got %0d cycles with both high expected 0", both_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = {$urandom()};
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_timeout();
        test_drops();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
